drum_motor_ctrl: RTL and testbench

- Downstream of the washer FSM (FSMW). Consumes its 2-bit motor command, its lockDoor output and the door_closed sensor.
- Drives the drum motor power stage with a soft-start/soft-stop PWM, a direction line and a brake line.
- Wash mode reverses drum direction periodically, with a mandatory stopped dwell before every direction change.
- Enforces a door interlock that cuts the motor immediately.

---
 rtl/drum_motor_ctrl_pkg.sv | 37 +++
 rtl/drum_pwm_gen.sv | 28 ++
 rtl/drum_motor_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_drum_motor_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_motor_ctrl_pkg.sv
// Shared motor command encodings, drum FSM states and saturating ramp helpers.
// The washer FSM drives motor_cmd with these same CMD_* encodings.
package drum_motor_ctrl_pkg;

   localparam logic [1:0] CMD_STOP = 2'b00;
   localparam logic [1:0] CMD_WASH = 2'b01;
   localparam logic [1:0] CMD_SPIN = 2'b10;
   localparam logic [1:0] CMD_RSVD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RAMP_UP   = 3'd1,
      ST_RUN       = 3'd2,
      ST_RAMP_DOWN = 3'd3,
      ST_DWELL     = 3'd4
   } motor_state_e;

   function automatic logic [7:0] ramp_up_step(input logic [7:0] cur,
                                               input logic [7:0] step,
                                               input logic [7:0] tgt);
      logic [8:0] sum;
      sum = {1'b0, cur} + {1'b0, step};
      if (sum >= {1'b0, tgt}) return tgt;
      return sum[7:0];
   endfunction

   // Compare in 9 bits so that cur - step can never wrap below the target.
   function automatic logic [7:0] ramp_down_step(input logic [7:0] cur,
                                                 input logic [7:0] step,
                                                 input logic [7:0] tgt);
      logic [8:0] floor_sum;
      floor_sum = {1'b0, step} + {1'b0, tgt};
      if ({1'b0, cur} <= floor_sum) return tgt;
      return cur - step;
   endfunction

endpackage

// File: rtl/drum_pwm_gen.sv
// Free-running 8-bit PWM: output high while the counter is below duty.
// i_force_off holds the gate low regardless of duty (used for the DWELL brake).
module drum_pwm_gen
   import drum_motor_ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [7:0] i_duty,
   input  logic       i_force_off,
   output logic       o_pwm
);

   logic [7:0] r_cnt;
   logic       r_pwm;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt <= 8'd0;
         r_pwm <= 1'b0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
         r_pwm <= (r_cnt < i_duty) && !i_force_off;
      end
   end

   assign o_pwm = r_pwm;

endmodule

// File: rtl/drum_motor_ctrl.sv
// Drum motor controller: soft-start/soft-stop ramping, wash reversals with a
// braked dwell before every direction change, and a sticky door interlock.
module drum_motor_ctrl
   import drum_motor_ctrl_pkg::*;
#(
   parameter logic [7:0] WASH_DUTY       = 8'd96,
   parameter logic [7:0] SPIN_DUTY       = 8'd240,
   parameter logic [7:0] RAMP_STEP       = 8'd4,
   parameter int         RAMP_DIV        = 16,
   parameter int         WASH_RUN_CYCLES = 200,
   parameter int         DWELL_CYCLES    = 20
)
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [1:0] i_motor_cmd,
   input  logic       i_lock_door,
   input  logic       i_door_closed,
   output logic       o_pwm_out,
   output logic       o_dir,
   output logic       o_brake,
   output logic [7:0] o_duty,
   output logic       o_at_speed,
   output logic       o_motor_busy,
   output logic       o_interlock_fault,
   output logic [2:0] o_dbg_state
);

   localparam logic [15:0] L_DIV_LAST   = 16'(RAMP_DIV - 1);
   localparam logic [15:0] L_RUN_LAST   = 16'(WASH_RUN_CYCLES - 1);
   localparam logic [15:0] L_DWELL_LAST = 16'(DWELL_CYCLES - 1);

   motor_state_e r_state;
   motor_state_e w_nxt_state;
   logic [7:0]   r_duty;
   logic [7:0]   w_nxt_duty;
   logic [7:0]   r_target;
   logic [7:0]   w_nxt_target;
   logic         r_dir;
   logic         w_nxt_dir;
   logic         r_spin;
   logic         w_nxt_spin;
   logic         r_fault;
   logic         w_nxt_fault;
   logic         r_brake;
   logic         r_at_speed;
   logic         r_busy;
   logic [15:0]  r_presc;
   logic [15:0]  w_nxt_presc;
   logic [15:0]  r_run_cnt;
   logic [15:0]  w_nxt_run_cnt;
   logic [15:0]  r_dwell_cnt;
   logic [15:0]  w_nxt_dwell_cnt;

   logic w_ilk_ok;
   logic w_trip;
   logic w_tick;
   logic w_cmd_stop;
   logic w_cmd_wash;
   logic w_cmd_spin;
   logic w_start;
   logic w_pwm_off;
   logic w_pwm;

   assign w_ilk_ok   = i_lock_door & i_door_closed;
   assign w_trip     = (r_state != ST_IDLE) && !w_ilk_ok;
   assign w_cmd_stop = (i_motor_cmd == CMD_STOP) || (i_motor_cmd == CMD_RSVD);
   assign w_cmd_wash = (i_motor_cmd == CMD_WASH);
   assign w_cmd_spin = (i_motor_cmd == CMD_SPIN);
   assign w_start    = (w_cmd_wash || w_cmd_spin) && w_ilk_ok && !r_fault;
   assign w_tick     = (r_presc == L_DIV_LAST);

   always_comb begin
      w_nxt_state     = r_state;
      w_nxt_duty      = r_duty;
      w_nxt_target    = r_target;
      w_nxt_dir       = r_dir;
      w_nxt_spin      = r_spin;
      w_nxt_fault     = r_fault;
      w_nxt_presc     = r_presc;
      w_nxt_run_cnt   = r_run_cnt;
      w_nxt_dwell_cnt = r_dwell_cnt;

      if (w_trip && (r_state != ST_DWELL)) begin
         w_nxt_state  = ST_DWELL;
         w_nxt_duty   = 8'd0;
         w_nxt_target = 8'd0;
         w_nxt_fault  = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  w_nxt_state  = ST_RAMP_UP;
                  w_nxt_dir    = 1'b0;
                  w_nxt_spin   = w_cmd_spin;
                  w_nxt_target = w_cmd_spin ? SPIN_DUTY : WASH_DUTY;
               end
            end

            ST_RAMP_UP, ST_RUN: begin
               if (w_cmd_stop) begin
                  w_nxt_target = 8'd0;
                  w_nxt_state  = ST_RAMP_DOWN;
               end else if (!r_spin && w_cmd_spin) begin
                  w_nxt_spin = 1'b1;
                  // A reversed drum must stop and dwell before spinning forward.
                  if (!r_dir) begin
                     w_nxt_target = SPIN_DUTY;
                     w_nxt_state  = ST_RAMP_UP;
                  end else begin
                     w_nxt_target = 8'd0;
                     w_nxt_state  = ST_RAMP_DOWN;
                  end
               end else if (r_spin && w_cmd_wash) begin
                  w_nxt_spin   = 1'b0;
                  w_nxt_target = WASH_DUTY;
                  w_nxt_state  = (r_duty > WASH_DUTY) ? ST_RAMP_DOWN : ST_RAMP_UP;
               end else if (r_state == ST_RAMP_UP) begin
                  w_nxt_presc = w_tick ? 16'd0 : r_presc + 16'd1;
                  if (r_duty == r_target) begin
                     w_nxt_state = ST_RUN;
                  end else if (w_tick) begin
                     w_nxt_duty = ramp_up_step(r_duty, RAMP_STEP, r_target);
                  end
               end else if (!r_spin) begin
                  if (r_run_cnt == L_RUN_LAST) begin
                     w_nxt_target = 8'd0;
                     w_nxt_state  = ST_RAMP_DOWN;
                  end else begin
                     w_nxt_run_cnt = r_run_cnt + 16'd1;
                  end
               end
            end

            ST_RAMP_DOWN: begin
               w_nxt_presc = w_tick ? 16'd0 : r_presc + 16'd1;
               if (r_duty == r_target) begin
                  w_nxt_state = (r_target == 8'd0) ? ST_DWELL : ST_RUN;
               end else if (w_tick) begin
                  w_nxt_duty = ramp_down_step(r_duty, RAMP_STEP, r_target);
               end
            end

            ST_DWELL: begin
               w_nxt_dwell_cnt = r_dwell_cnt + 16'd1;
               if (w_trip) begin
                  w_nxt_fault  = 1'b1;
                  w_nxt_duty   = 8'd0;
                  w_nxt_target = 8'd0;
               end
               if (r_dwell_cnt == L_DWELL_LAST) begin
                  if (r_fault || w_trip || w_cmd_stop) begin
                     w_nxt_state = ST_IDLE;
                  end else if (w_cmd_wash) begin
                     w_nxt_state  = ST_RAMP_UP;
                     w_nxt_dir    = ~r_dir;
                     w_nxt_spin   = 1'b0;
                     w_nxt_target = WASH_DUTY;
                  end else begin
                     w_nxt_state  = ST_RAMP_UP;
                     w_nxt_dir    = 1'b0;
                     w_nxt_spin   = 1'b1;
                     w_nxt_target = SPIN_DUTY;
                  end
               end
            end

            default: w_nxt_state = ST_IDLE;
         endcase
      end

      // Only an explicit stop with a closed, locked door acknowledges a trip.
      if ((i_motor_cmd == CMD_STOP) && w_ilk_ok) begin
         w_nxt_fault = 1'b0;
      end

      if (w_nxt_state != r_state) begin
         w_nxt_presc     = 16'd0;
         w_nxt_run_cnt   = 16'd0;
         w_nxt_dwell_cnt = 16'd0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_duty      <= 8'd0;
         r_target    <= 8'd0;
         r_dir       <= 1'b0;
         r_spin      <= 1'b0;
         r_fault     <= 1'b0;
         r_brake     <= 1'b0;
         r_at_speed  <= 1'b0;
         r_busy      <= 1'b0;
         r_presc     <= 16'd0;
         r_run_cnt   <= 16'd0;
         r_dwell_cnt <= 16'd0;
      end else begin
         r_state     <= w_nxt_state;
         r_duty      <= w_nxt_duty;
         r_target    <= w_nxt_target;
         r_dir       <= w_nxt_dir;
         r_spin      <= w_nxt_spin;
         r_fault     <= w_nxt_fault;
         r_brake     <= (w_nxt_state == ST_DWELL);
         r_at_speed  <= (w_nxt_state == ST_RUN);
         r_busy      <= (w_nxt_state != ST_IDLE);
         r_presc     <= w_nxt_presc;
         r_run_cnt   <= w_nxt_run_cnt;
         r_dwell_cnt <= w_nxt_dwell_cnt;
      end
   end

   // The gate is registered from next-cycle duty/state so it lines up with o_duty.
   assign w_pwm_off = (w_nxt_state == ST_DWELL);

   drum_pwm_gen u_pwm (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_duty      (w_nxt_duty),
      .i_force_off (w_pwm_off),
      .o_pwm       (w_pwm)
   );

   assign o_pwm_out         = w_pwm;
   assign o_dir             = r_dir;
   assign o_brake           = r_brake;
   assign o_duty            = r_duty;
   assign o_at_speed        = r_at_speed;
   assign o_motor_busy      = r_busy;
   assign o_interlock_fault = r_fault;
   assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_drum_motor_ctrl.sv
// Scenario bench for drum_motor_ctrl: expected per-cycle traces are generated
// from the ramp/run/dwell rules and compared with the DUT one cycle at a time.
module tb_drum_motor_ctrl;
  import drum_motor_ctrl_pkg::*;

  localparam int T_WASH  = 96;
  localparam int T_SPIN  = 240;
  localparam int T_STEP  = 16;
  localparam int T_DIV   = 1;
  localparam int T_RUN   = 10;
  localparam int T_DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cmd = CMD_STOP;
  logic       lock_door = 1'b1;
  logic       door_closed = 1'b1;
  logic       pwm_out, dir, brake, at_speed, motor_busy, interlock_fault;
  logic [7:0] duty;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // expected vector layout: {duty[7:0], at_speed, brake, busy, dir, fault}
  logic [12:0] exp_q[$];

  drum_motor_ctrl #(
    .WASH_DUTY      (8'(T_WASH)),
    .SPIN_DUTY      (8'(T_SPIN)),
    .RAMP_STEP      (8'(T_STEP)),
    .RAMP_DIV       (T_DIV),
    .WASH_RUN_CYCLES(T_RUN),
    .DWELL_CYCLES   (T_DWELL)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_motor_cmd      (cmd),
    .i_lock_door      (lock_door),
    .i_door_closed    (door_closed),
    .o_pwm_out        (pwm_out),
    .o_dir            (dir),
    .o_brake          (brake),
    .o_duty           (duty),
    .o_at_speed       (at_speed),
    .o_motor_busy     (motor_busy),
    .o_interlock_fault(interlock_fault),
    .o_dbg_state      (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // Cycles since reset, modulo 256: the PWM phase reference.
  logic [7:0] tb_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 8'd0;
    else     tb_cnt <= tb_cnt + 8'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [12:0] mk(input int d, input bit as, input bit br,
                                     input bit busy, input bit dr, input bit flt);
    return {8'(d), as, br, busy, dr, flt};
  endfunction

  function logic [12:0] obs();
    return {duty, at_speed, brake, motor_busy, dir, interlock_fault};
  endfunction

  // Reference model: expected traces built from the ramp/run/dwell rules.
  task automatic gen_ramp(input int from, input int to, input bit dr, input bit flt);
    int d;
    d = from;
    exp_q.push_back(mk(d, 0, 0, 1, dr, flt));
    while (d != to) begin
      if (to > d) d = (d + T_STEP > to) ? to : d + T_STEP;
      else        d = (d - T_STEP < to) ? to : d - T_STEP;
      exp_q.push_back(mk(d, 0, 0, 1, dr, flt));
    end
  endtask

  task automatic gen_run(input int n, input int d, input bit dr, input bit flt);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(d, 1, 0, 1, dr, flt));
  endtask

  task automatic gen_dwell(input int n, input bit dr, input bit flt);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 0, 1, 1, dr, flt));
  endtask

  task automatic gen_idle(input int n, input bit dr, input bit flt);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 0, 0, 0, dr, flt));
  endtask

  task automatic test_reset();
    logic [12:0] e;
    logic        ep;
    int          cyc;
    rst = 1'b1;
    cmd = CMD_STOP;
    #2;
    n_checks++;
    if ({pwm_out, obs()} !== 14'd0) $display("FAIL reset_state: got %h required 0", {pwm_out, obs()});
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    gen_idle(3, 0, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      ep = (8'(tb_cnt - 8'd1) < e[12:5]) && !e[3];
      n_checks++;
      if ({pwm_out, obs()} !== {ep, e})
        $display("FAIL reset_idle cyc %0d: got pwm=%b vec=%h required pwm=%b vec=%h", cyc, pwm_out, obs(), ep, e);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_wash();
    logic [12:0] e;
    logic        ep;
    int          cyc;
    cmd = CMD_WASH;
    gen_ramp(0, T_WASH, 0, 0);
    gen_run(T_RUN, T_WASH, 0, 0);
    gen_ramp(T_WASH, 0, 0, 0);
    gen_dwell(T_DWELL, 0, 0);
    gen_ramp(0, T_WASH, 1, 0);
    gen_run($urandom_range(1, 8), T_WASH, 1, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      ep = (8'(tb_cnt - 8'd1) < e[12:5]) && !e[3];
      n_checks++;
      if ({pwm_out, obs()} !== {ep, e})
        $display("FAIL wash cyc %0d: got pwm=%b vec=%h required pwm=%b vec=%h", cyc, pwm_out, obs(), ep, e);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_wash_to_spin();
    logic [12:0] e;
    logic        ep;
    int          cyc;
    cmd = CMD_SPIN;
    gen_ramp(T_WASH, 0, 1, 0);
    gen_dwell(T_DWELL, 1, 0);
    gen_ramp(0, T_SPIN, 0, 0);
    gen_run(3, T_SPIN, 0, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      ep = (8'(tb_cnt - 8'd1) < e[12:5]) && !e[3];
      n_checks++;
      if ({pwm_out, obs()} !== {ep, e})
        $display("FAIL wash_to_spin cyc %0d: got pwm=%b vec=%h required pwm=%b vec=%h", cyc, pwm_out, obs(), ep, e);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_spin_pwm();
    logic [12:0] e;
    logic        ep;
    int          cyc;
    int          highs;
    gen_run(256, T_SPIN, 0, 0);
    cyc   = 0;
    highs = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      ep = (8'(tb_cnt - 8'd1) < e[12:5]) && !e[3];
      if (pwm_out === 1'b1) highs++;
      n_checks++;
      if ({pwm_out, obs()} !== {ep, e})
        $display("FAIL spin_run cyc %0d: got pwm=%b vec=%h required pwm=%b vec=%h", cyc, pwm_out, obs(), ep, e);
      else n_pass++;
      cyc++;
    end
    n_checks++;
    if (highs != T_SPIN) $display("FAIL spin_pwm_highs: got %0d of 256 required %0d", highs, T_SPIN);
    else n_pass++;
  endtask

  task automatic test_spin_to_wash();
    logic [12:0] e;
    logic        ep;
    int          cyc;
    cmd = CMD_WASH;
    gen_ramp(T_SPIN, T_WASH, 0, 0);
    gen_run($urandom_range(1, 8), T_WASH, 0, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      ep = (8'(tb_cnt - 8'd1) < e[12:5]) && !e[3];
      n_checks++;
      if ({pwm_out, obs()} !== {ep, e})
        $display("FAIL spin_to_wash cyc %0d: got pwm=%b vec=%h required pwm=%b vec=%h", cyc, pwm_out, obs(), ep, e);
      else n_pass++;
      cyc++;
    end
    cmd = CMD_SPIN;
    gen_ramp(T_WASH, T_SPIN, 0, 0);
    gen_run(3, T_SPIN, 0, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      ep = (8'(tb_cnt - 8'd1) < e[12:5]) && !e[3];
      n_checks++;
      if ({pwm_out, obs()} !== {ep, e})
        $display("FAIL wash_fwd_to_spin cyc %0d: got pwm=%b vec=%h required pwm=%b vec=%h", cyc, pwm_out, obs(), ep, e);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_interlock();
    logic [12:0] e;
    logic        ep;
    int          cyc;
    int          phase;
    gen_run($urandom_range(1, 20), T_SPIN, 0, 0);
    for (phase = 0; phase < 5; phase++) begin
      cyc = 0;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        @(posedge clk); #1;
        ep = (8'(tb_cnt - 8'd1) < e[12:5]) && !e[3];
        n_checks++;
        if ({pwm_out, obs()} !== {ep, e})
          $display("FAIL interlock phase %0d cyc %0d: got pwm=%b vec=%h required pwm=%b vec=%h",
                   phase, cyc, pwm_out, obs(), ep, e);
        else n_pass++;
        cyc++;
      end
      case (phase)
        0: begin
          if ($urandom_range(0, 1) == 1) door_closed = 1'b0;
          else                           lock_door   = 1'b0;
          gen_dwell(T_DWELL, 0, 1);
          gen_idle($urandom_range(2, 5), 0, 1);
        end
        1: begin
          door_closed = 1'b1;
          lock_door   = 1'b1;
          gen_idle($urandom_range(2, 6), 0, 1);
        end
        2: begin
          cmd = CMD_STOP;
          gen_idle(1, 0, 0);
        end
        3: begin
          cmd = CMD_SPIN;
          gen_ramp(0, T_SPIN, 0, 0);
          gen_run(4, T_SPIN, 0, 0);
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_reserved_and_reset();
    logic [12:0] e;
    logic        ep;
    int          cyc;
    cmd = CMD_RSVD;
    gen_ramp(T_SPIN, 0, 0, 0);
    gen_dwell(T_DWELL, 0, 0);
    gen_idle($urandom_range(3, 8), 0, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      ep = (8'(tb_cnt - 8'd1) < e[12:5]) && !e[3];
      n_checks++;
      if ({pwm_out, obs()} !== {ep, e})
        $display("FAIL reserved cyc %0d: got pwm=%b vec=%h required pwm=%b vec=%h", cyc, pwm_out, obs(), ep, e);
      else n_pass++;
      cyc++;
    end
    cmd = CMD_WASH;
    gen_ramp(0, 48, 0, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      ep = (8'(tb_cnt - 8'd1) < e[12:5]) && !e[3];
      n_checks++;
      if ({pwm_out, obs()} !== {ep, e})
        $display("FAIL ramp_before_reset cyc %0d: got pwm=%b vec=%h required pwm=%b vec=%h", cyc, pwm_out, obs(), ep, e);
      else n_pass++;
      cyc++;
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({pwm_out, obs()} !== 14'd0) $display("FAIL async_reset: got %h required 0", {pwm_out, obs()});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({pwm_out, obs()} !== 14'd0) $display("FAIL reset_held: got %h required 0", {pwm_out, obs()});
    else n_pass++;
    rst = 1'b0;
    cmd = CMD_STOP;
    gen_idle(2, 0, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(posedge clk); #1;
      ep = (8'(tb_cnt - 8'd1) < e[12:5]) && !e[3];
      n_checks++;
      if ({pwm_out, obs()} !== {ep, e})
        $display("FAIL post_reset_idle cyc %0d: got pwm=%b vec=%h required pwm=%b vec=%h", cyc, pwm_out, obs(), ep, e);
      else n_pass++;
      cyc++;
    end
  endtask

  initial begin
    test_reset();
    test_wash();
    test_wash_to_spin();
    test_spin_pwm();
    test_spin_to_wash();
    test_interlock();
    test_reserved_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
